// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a 2-digit multiplexed 7-segment display from a two-digit BCD value
//   (ones/tens). Each digit gets a time slot of REFRESH_DIV cycles. The first
//   GUARD cycles of every slot keep all anodes off to stop ghosting at the
//   digit switch. A new value is first held in a shadow register. It is copied
//   to the displayed digits only at a frame boundary, so a frame never mixes
//   old and new digits.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a tens digit of 0 is left dark for its whole slot.
//   When undefined, the tens digit is always shown.
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  asynchronous active-high reset
//   in_valid    in   1  bcd0/bcd1 carry a new value
//   in_ready    out  1  shadow register free (combinational, = !pending)
//   bcd0        in   4  ones digit (BCD)
//   bcd1        in   4  tens digit (BCD)
//   blank       in   1  level; forces all anodes inactive, scanning continues
//   seg         out  7  {g,f,e,d,c,b,a} segment drive, registered
//   an          out  2  an[0]=ones, an[1]=tens anode drive, registered
//   frame_tick  out  1  one-cycle pulse after each frame boundary, registered

module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_OFF    = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  typedef enum logic {
    SLOT_D0 = 1'b0,
    SLOT_D1 = 1'b1
  } slot_t;

  // Active-high segment pattern {g..a}. Codes 10-15 show 'E'.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b1111001;
    endcase
    return pat;
  endfunction

  // Convert an active-high segment pattern to the pin polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] act);
    return SEG_ACTIVE_LOW ? ~act : act;
  endfunction

  // Convert an active-high anode pattern to the pin polarity.
  function automatic logic [1:0] an_polarity(input logic [1:0] act);
    return AN_ACTIVE_LOW ? ~act : act;
  endfunction

  logic [CW-1:0] cnt_r;
  slot_t         slot_r;
  logic [3:0]    disp0_r, disp1_r;
  logic [3:0]    shadow0_r, shadow1_r;
  logic          pending_r;

  logic          cnt_wrap_s;
  logic          boundary_s;
  logic          transfer_s;
  logic [6:0]    seg_nxt_s;
  logic [1:0]    an_nxt_s;
  logic [3:0]    digit_s;
  logic [1:0]    an_act_s;

  assign in_ready   = ~pending_r;
  assign cnt_wrap_s = (cnt_r == CNT_MAX);
  // The frame ends on the last cycle of the tens slot.
  assign boundary_s = cnt_wrap_s && (slot_r == SLOT_D1);
  assign transfer_s = in_valid && ~pending_r;

  // Slot divider and digit-slot state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      slot_r <= SLOT_D0;
    end else if (cnt_wrap_s) begin
      cnt_r <= {CW{1'b0}};
      case (slot_r)
        SLOT_D0: slot_r <= SLOT_D1;
        SLOT_D1: slot_r <= SLOT_D0;
        default: slot_r <= SLOT_D0;
      endcase
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Input handshake into the shadow register and frame-aligned display update.
  // A transfer is only possible while nothing is pending. So a transfer on the
  // boundary cycle never competes with a display update. That value waits for
  // the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp0_r   <= 4'd0;
      disp1_r   <= 4'd0;
      shadow0_r <= 4'd0;
      shadow1_r <= 4'd0;
      pending_r <= 1'b0;
    end else begin
      if (boundary_s) begin
        if (pending_r) begin
          disp0_r <= shadow0_r;
          disp1_r <= shadow1_r;
        end
        pending_r <= 1'b0;
      end
      if (transfer_s) begin
        shadow0_r <= bcd0;
        shadow1_r <= bcd1;
        pending_r <= 1'b1;
      end
    end
  end

  // Next segment/anode drive from the current slot, guard band and blank.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    an_nxt_s  = AN_OFF;
    digit_s   = disp0_r;
    an_act_s  = 2'b01;
    case (slot_r)
      SLOT_D0: begin
        digit_s  = disp0_r;
        an_act_s = 2'b01;
      end
      SLOT_D1: begin
        digit_s  = disp1_r;
        an_act_s = 2'b10;
      end
      default: begin
        digit_s  = disp0_r;
        an_act_s = 2'b01;
      end
    endcase
    if ((cnt_r < CNT_GUARD) || blank) begin
      seg_nxt_s = SEG_OFF;
      an_nxt_s  = AN_OFF;
    end else if (LZB_EN && (slot_r == SLOT_D1) && (disp1_r == 4'd0)) begin
      seg_nxt_s = SEG_OFF;
      an_nxt_s  = AN_OFF;
    end else begin
      seg_nxt_s = seg_polarity(decode_digit(digit_s));
      an_nxt_s  = an_polarity(an_act_s);
    end
  end

  // Output registers: one cycle of latency from the scan state to the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt_s;
      an         <= an_nxt_s;
      frame_tick <= boundary_s;
    end
  end

endmodule
